// File: rtl/csr_io_unit_if.sv
// CSR I/O bus between the decode/control path (master) and csr_io_unit (slave).
// Carries the HEX write strobe/data, the pipeline stall and the switch read data.
interface csr_io_unit_if;
  logic        stall_EX;
  logic        gpio_we;
  logic [31:0] gpio_wdata;
  logic [31:0] gpio_rdata;

  modport master (
    output stall_EX,
    output gpio_we,
    output gpio_wdata,
    input  gpio_rdata
  );

  modport slave (
    input  stall_EX,
    input  gpio_we,
    input  gpio_wdata,
    output gpio_rdata
  );
endinterface

// File: rtl/csr_io_unit.sv
// CSR I/O responder: HEX display register with registered seven-segment decode,
// and a two-flop synchronised, whole-bus debounced switch register for reads.
module csr_io_unit #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter bit          BLANK_LZ        = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  csr_io_unit_if.slave bus,
  input  logic [17:0]  sw_raw,
  output logic [31:0]  hex_value,
  output logic [6:0]   hex0,
  output logic [6:0]   hex1,
  output logic [6:0]   hex2,
  output logic [6:0]   hex3,
  output logic [6:0]   hex4,
  output logic [6:0]   hex5,
  output logic [6:0]   hex6,
  output logic [6:0]   hex7
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Digit k is a leading zero when it and every more significant nibble are zero.
  function automatic logic is_leading_zero(input logic [31:0] v, input int unsigned k);
    logic [31:0] upper;
    upper = v >> (4 * k);
    return (k != 0) && (upper == 32'd0);
  endfunction

  function automatic logic [6:0] seg_reset(input int unsigned k);
    logic [6:0] s;
    if (BLANK_LZ && (k != 0)) begin
      s = SEG_BLANK;
    end else begin
      s = SEG_ZERO;
    end
    return s;
  endfunction

  logic [31:0] hex_q, hex_d;
  logic [6:0]  seg_q [8];
  logic [6:0]  seg_d [8];

  logic [17:0] sync1_q, sync2_q;
  logic [17:0] cand_q, cand_d;
  logic [17:0] stable_q, stable_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q;

  always_comb begin
    hex_d = hex_q;
    if (bus.gpio_we && !bus.stall_EX) begin
      hex_d = bus.gpio_wdata;
    end else begin
      hex_d = hex_q;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < 8; k++) begin
      seg_d[k] = seg7(hex_q[4*k +: 4]);
      if (BLANK_LZ && is_leading_zero(hex_q, k)) begin
        seg_d[k] = SEG_BLANK;
      end else begin
        seg_d[k] = seg7(hex_q[4*k +: 4]);
      end
    end
  end

  // Any bit change on the synchronised bus restarts the count; it saturates once accepted.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = 16'd0;
    end else if (cnt_q == (DEBOUNCE_CYCLES - 16'd1)) begin
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_q <= 32'd0;
      for (int unsigned k = 0; k < 8; k++) begin
        seg_q[k] <= seg_reset(k);
      end
    end else begin
      hex_q <= hex_d;
      for (int unsigned k = 0; k < 8; k++) begin
        seg_q[k] <= seg_d[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 18'd0;
      sync2_q  <= 18'd0;
      cand_q   <= 18'd0;
      stable_q <= 18'd0;
      cnt_q    <= 16'd0;
      rdata_q  <= 32'd0;
    end else begin
      sync1_q  <= sw_raw;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rdata_q  <= {14'd0, stable_q};
    end
  end

  assign bus.gpio_rdata = rdata_q;
  assign hex_value      = hex_q;
  assign hex0 = seg_q[0];
  assign hex1 = seg_q[1];
  assign hex2 = seg_q[2];
  assign hex3 = seg_q[3];
  assign hex4 = seg_q[4];
  assign hex5 = seg_q[5];
  assign hex6 = seg_q[6];
  assign hex7 = seg_q[7];

endmodule

// File: tb/tb_csr_io_unit.sv
// Self-checking bench for csr_io_unit: two instances (leading zeros shown / blanked),
// directed scenarios plus randomized traffic against a window-based reference model.
module tb_csr_io_unit;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [17:0] sw_raw = 18'd0;
  logic [31:0] hv_a, hv_b;
  logic [6:0]  ha [8];
  logic [6:0]  hb [8];

  always #5 clk = ~clk;

  csr_io_unit_if bus_a ();
  csr_io_unit_if bus_b ();

  csr_io_unit #(.DEBOUNCE_CYCLES(16'd4), .BLANK_LZ(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .sw_raw(sw_raw), .hex_value(hv_a),
    .hex0(ha[0]), .hex1(ha[1]), .hex2(ha[2]), .hex3(ha[3]),
    .hex4(ha[4]), .hex5(ha[5]), .hex6(ha[6]), .hex7(ha[7])
  );

  csr_io_unit #(.DEBOUNCE_CYCLES(16'd4), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .sw_raw(sw_raw), .hex_value(hv_b),
    .hex0(hb[0]), .hex1(hb[1]), .hex2(hb[2]), .hex3(hb[3]),
    .hex4(hb[4]), .hex5(hb[5]), .hex6(hb[6]), .hex7(hb[7])
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [6:0]  SEG_TBL [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [31:0] hex_m;
  logic [6:0]  seg_a_m [8];
  logic [6:0]  seg_b_m [8];
  logic [17:0] stable_m;
  logic [31:0] rdata_m;
  logic [17:0] hist [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic st, input logic [31:0] wd);
    bus_a.gpio_we = we;  bus_a.stall_EX = st;  bus_a.gpio_wdata = wd;
    bus_b.gpio_we = we;  bus_b.stall_EX = st;  bus_b.gpio_wdata = wd;
  endtask

  task automatic model_reset();
    hex_m = 32'd0;
    for (int k = 0; k < 8; k++) begin
      seg_a_m[k] = 7'b1000000;
      seg_b_m[k] = (k == 0) ? 7'b1000000 : 7'b1111111;
    end
    stable_m = 18'd0;
    rdata_m  = 32'd0;
    hist.delete();
    for (int i = 0; i < D + 3; i++) hist.push_back(18'd0);
  endtask

  // Digit k is blank (BLANK_LZ=1) iff nibbles k..7 of v are all zero, k >= 1.
  function automatic logic [6:0] digit_b(input logic [31:0] v, input int k);
    logic all_zero;
    all_zero = 1'b1;
    for (int j = k; j < 8; j++) if (v[4*j +: 4] != 4'h0) all_zero = 1'b0;
    if (k != 0 && all_zero) return 7'b1111111;
    return SEG_TBL[v[4*k +: 4]];
  endfunction

  task automatic compare_all();
    check_eq("a_hex_value", hv_a, hex_m);
    check_eq("b_hex_value", hv_b, hex_m);
    check_eq("a_rdata", bus_a.gpio_rdata, rdata_m);
    check_eq("b_rdata", bus_b.gpio_rdata, rdata_m);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("a_hex%0d", k), {25'd0, ha[k]}, {25'd0, seg_a_m[k]});
      check_eq($sformatf("b_hex%0d", k), {25'd0, hb[k]}, {25'd0, seg_b_m[k]});
    end
  endtask

  // One clock: capture pre-edge inputs, advance model at the edge, compare at negedge.
  task automatic tick();
    logic        we_s, st_s, all_eq;
    logic [31:0] wd_s;
    logic [17:0] sw_s;
    we_s = bus_a.gpio_we; st_s = bus_a.stall_EX; wd_s = bus_a.gpio_wdata; sw_s = sw_raw;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 8; k++) begin
        seg_a_m[k] = SEG_TBL[hex_m[4*k +: 4]];
        seg_b_m[k] = digit_b(hex_m, k);
      end
      if (we_s && !st_s) hex_m = wd_s;
      rdata_m = {14'd0, stable_m};
      hist.push_back(sw_s);
      void'(hist.pop_front());
      all_eq = 1'b1;
      for (int i = 1; i <= D; i++) if (hist[i] != hist[0]) all_eq = 1'b0;
      if (all_eq) stable_m = hist[0];
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [31:0] wd;
    int hold;
    drive(1'b0, 1'b0, 32'd0);
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Mid-sim asynchronous reset, checked before any edge
    drive(1'b1, 1'b0, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    #1;
    check_eq("rst_hex_value", hv_a, 32'd0);
    check_eq("rst_rdata", bus_a.gpio_rdata, 32'd0);
    for (int k = 0; k < 8; k++) check_eq("rst_a_seg", {25'd0, ha[k]}, {25'd0, 7'b1000000});
    check_eq("rst_b_hex0", {25'd0, hb[0]}, {25'd0, 7'b1000000});
    check_eq("rst_b_hex7", {25'd0, hb[7]}, {25'd0, 7'b1111111});
    tick();
    rst = 1'b0;

    // Write then decode one edge later
    drive(1'b1, 1'b0, 32'h89ABCDEF);
    tick();
    check_eq("wr_hex_value", hv_a, 32'h89ABCDEF);
    drive(1'b0, 1'b0, 32'd0);
    tick();
    check_eq("wr_hex0", {25'd0, ha[0]}, {25'd0, 7'b0001110});
    check_eq("wr_hex1", {25'd0, ha[1]}, {25'd0, 7'b0000110});
    check_eq("wr_hex7", {25'd0, ha[7]}, {25'd0, 7'b0000000});

    // Stalled write is suppressed
    drive(1'b1, 1'b1, 32'h12345678);
    repeat (5) begin
      tick();
      check_eq("stall_hex_value", hv_a, 32'h89ABCDEF);
      check_eq("stall_hex0", {25'd0, ha[0]}, {25'd0, 7'b0001110});
    end

    // Leading-zero blanking
    drive(1'b1, 1'b0, 32'h00000A05);
    tick();
    drive(1'b0, 1'b0, 32'd0);
    tick();
    check_eq("lz_hex0", {25'd0, hb[0]}, {25'd0, 7'b0010010});
    check_eq("lz_hex1", {25'd0, hb[1]}, {25'd0, 7'b1000000});
    check_eq("lz_hex2", {25'd0, hb[2]}, {25'd0, 7'b0001000});
    for (int k = 3; k < 8; k++) check_eq("lz_hi", {25'd0, hb[k]}, {25'd0, 7'b1111111});
    drive(1'b1, 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0);
    tick();
    check_eq("lz0_hex0", {25'd0, hb[0]}, {25'd0, 7'b1000000});
    for (int k = 1; k < 8; k++) check_eq("lz0_hi", {25'd0, hb[k]}, {25'd0, 7'b1111111});

    // Debounce latency: 0 at edge 7, value at edge 8
    sw_raw = 18'h2A5A5;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 7) check_eq("deb_edge7", bus_a.gpio_rdata, 32'd0);
      if (e == 8) check_eq("deb_edge8", bus_a.gpio_rdata, 32'h0002A5A5);
    end

    // Glitch shorter than the debounce window never reaches the output
    sw_raw = 18'd0;
    repeat (12) tick();
    sw_raw = 18'h3FFFF;
    repeat (3) tick();
    sw_raw = 18'd0;
    repeat (12) begin
      tick();
      check_eq("glitch_rdata", bus_a.gpio_rdata, 32'd0);
    end

    // Reset during a held change restarts the count after release
    sw_raw = 18'h15555;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check_eq("rst_deb_rdata", bus_a.gpio_rdata, 32'd0);
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 7) check_eq("rst_deb_e7", bus_a.gpio_rdata, 32'd0);
      if (e == 8) check_eq("rst_deb_e8", bus_a.gpio_rdata, 32'h00015555);
    end

    // Randomized traffic: writes, stalls, switch changes of random hold length
    hold = 0;
    for (int c = 0; c < 400; c++) begin
      wd = $urandom();
      wd = wd >> $urandom_range(0, 31);
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), wd);
      if (hold == 0) begin
        sw_raw = 18'($urandom());
        hold = $urandom_range(1, 9);
      end else begin
        hold--;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
